// File: rtl/mem_wb_stage_pkg.sv
// Shared widths for the MEM/WB boundary and the write-back value select.
package mem_wb_stage_pkg;

  // Datapath widths shared by every pipeline stage.
  localparam int ADDRESS_LEN   = 32;
  localparam int REGISTER_LEN  = 32;
  localparam int REG_ADDR_LEN  = 4;

  // Default width of the performance counters.
  localparam int CNT_W_DEFAULT = 32;

  // Loads retire the memory data, everything else retires the ALU result.
  function automatic logic [REGISTER_LEN-1:0] wb_select(
    input logic                    mem_read,
    input logic [REGISTER_LEN-1:0] mem_data,
    input logic [REGISTER_LEN-1:0] alu_res
  );
    return mem_read ? mem_data : alu_res;
  endfunction

endpackage

// File: rtl/mem_wb_stage_sat_counter.sv
// Saturating event counter: synchronous clear has priority over increment,
// and the count sticks at all-ones instead of wrapping.
module sat_counter
  import mem_wb_stage_pkg::*;
#(
  parameter int W = CNT_W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;
  logic         at_max;

  assign at_max = (count_q == {W{1'b1}});

  // Next count: clear first, otherwise increment unless already saturated.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && !at_max) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline boundary. Captures MEM-stage results, selects the
// write-back value and drives the register-file write port, which doubles
// as the WB forwarding source. While the memory stage is frozen a bubble is
// inserted so the held instruction retires exactly once, on the first
// unfrozen edge. All outputs come straight from flops.
//
// Flow control: there is no valid/ready handshake here. freeze_mem acts as
// the inverse of a ready: when it is high the MEM outputs are not
// trustworthy, nothing is accepted, and valid_out drops for that cycle.
// valid_in marks a real instruction; an instruction transfers (retires) on
// any edge where valid_in=1 and freeze_mem=0.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    freeze_mem,
  input  logic                    valid_in,
  input  logic [ADDRESS_LEN-1:0]  pc_in,
  input  logic                    wb_en_in,
  input  logic                    mem_read_in,
  input  logic [REG_ADDR_LEN-1:0] dest_in,
  input  logic [REGISTER_LEN-1:0] alu_res_in,
  input  logic [REGISTER_LEN-1:0] mem_data_in,
  input  logic                    clr_cnt,
  output logic                    valid_out,
  output logic [ADDRESS_LEN-1:0]  pc_out,
  output logic                    wb_en_out,
  output logic [REG_ADDR_LEN-1:0] wb_dest_out,
  output logic [REGISTER_LEN-1:0] wb_value_out,
  output logic [ADDRESS_LEN-1:0]  last_pc_out,
  output logic [CNT_W-1:0]        retire_cnt,
  output logic [CNT_W-1:0]        load_cnt,
  output logic [CNT_W-1:0]        stall_cnt
);

  // Pipeline capture register.
  logic                    valid_q,   valid_d;
  logic                    wb_en_q,   wb_en_d;
  logic [ADDRESS_LEN-1:0]  pc_q,      pc_d;
  logic [REG_ADDR_LEN-1:0] dest_q,    dest_d;
  logic [REGISTER_LEN-1:0] value_q,   value_d;
  logic [ADDRESS_LEN-1:0]  last_pc_q, last_pc_d;

  // Events feeding the performance counters.
  logic retire_ev;
  logic load_ev;
  logic stall_ev;

  assign retire_ev = ~freeze_mem & valid_in;
  assign load_ev   = retire_ev & mem_read_in;
  assign stall_ev  = freeze_mem;

  // Next-state of the capture register: capture when unfrozen, otherwise
  // insert a bubble and keep the data fields stable for forwarding.
  always_comb begin
    valid_d   = 1'b0;
    wb_en_d   = 1'b0;
    pc_d      = pc_q;
    dest_d    = dest_q;
    value_d   = value_q;
    last_pc_d = last_pc_q;
    if (!freeze_mem) begin
      valid_d = valid_in;
      wb_en_d = valid_in & wb_en_in;
      pc_d    = pc_in;
      dest_d  = dest_in;
      value_d = wb_select(mem_read_in, mem_data_in, alu_res_in);
    end
    if (retire_ev) begin
      last_pc_d = pc_in;
    end
  end

  // Capture register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q   <= 1'b0;
      wb_en_q   <= 1'b0;
      pc_q      <= '0;
      dest_q    <= '0;
      value_q   <= '0;
      last_pc_q <= '0;
    end else begin
      valid_q   <= valid_d;
      wb_en_q   <= wb_en_d;
      pc_q      <= pc_d;
      dest_q    <= dest_d;
      value_q   <= value_d;
      last_pc_q <= last_pc_d;
    end
  end

  assign valid_out    = valid_q;
  assign wb_en_out    = wb_en_q;
  assign pc_out       = pc_q;
  assign wb_dest_out  = dest_q;
  assign wb_value_out = value_q;
  assign last_pc_out  = last_pc_q;

  // Retired instructions.
  sat_counter #(.W(CNT_W)) u_retire_cnt (
    .clk   (clk),
    .rst_n (rst),
    .inc   (retire_ev),
    .clr   (clr_cnt),
    .count (retire_cnt)
  );

  // Retired loads.
  sat_counter #(.W(CNT_W)) u_load_cnt (
    .clk   (clk),
    .rst_n (rst),
    .inc   (load_ev),
    .clr   (clr_cnt),
    .count (load_cnt)
  );

  // Cycles spent frozen.
  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst),
    .inc   (stall_ev),
    .clr   (clr_cnt),
    .count (stall_cnt)
  );

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
Pipeline boundary directly downstream of the memory stage. It captures each instruction's MEM-stage results, selects the write-back value (load data or ALU result), and drives the register-file write port and the WB forwarding path. It is freeze-aware: while the memory stage stalls on a cache miss it inserts bubbles, so no instruction retires twice. It also keeps saturating retire/load/stall counters for performance debug.

Parameters:
ADDRESS_LEN, 32, PC width
REGISTER_LEN, 32, data/ALU result width
REG_ADDR_LEN, 4, register-file index width (R0..R15)
CNT_W, 32, width of each performance counter

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
freeze_mem  in  1  memory stage not ready (cache busy); MEM results invalid this cycle
valid_in  in  1  MEM stage holds a real instruction (0 = bubble)
pc_in  in  ADDRESS_LEN  PC of MEM-stage instruction
wb_en_in  in  1  instruction writes a register
mem_read_in  in  1  instruction is a load
dest_in  in  REG_ADDR_LEN  destination register
alu_res_in  in  REGISTER_LEN  ALU result / effective address
mem_data_in  in  REGISTER_LEN  load data from memory stage
clr_cnt  in  1  synchronous clear of all counters
valid_out  out  1  WB stage holds a real instruction
pc_out  out  ADDRESS_LEN  PC of WB instruction
wb_en_out  out  1  register-file write enable (also forwarding valid)
wb_dest_out  out  REG_ADDR_LEN  register-file write index
wb_value_out  out  REGISTER_LEN  register-file write data
last_pc_out  out  ADDRESS_LEN  PC of most recently retired instruction
retire_cnt  out  CNT_W  retired instructions
load_cnt  out  CNT_W  retired loads
stall_cnt  out  CNT_W  cycles with freeze_mem=1

Behaviour:
- Reset (rst=0, asynchronous): every output and internal register = 0. Reset takes effect immediately, including mid-freeze. After release, the first capture occurs on the next rising edge.
- Latency: 1 cycle. Inputs sampled at edge N appear on outputs after edge N.
- Capture when freeze_mem=0:
  - valid_out <= valid_in
  - wb_en_out <= valid_in & wb_en_in
  - wb_dest_out <= dest_in
  - pc_out <= pc_in
  - wb_value_out <= mem_read_in ? mem_data_in : alu_res_in
- Capture when freeze_mem=1 (bubble insertion):
  - valid_out <= 0 and wb_en_out <= 0.
  - pc_out, wb_dest_out and wb_value_out hold their previous values.
  - The held MEM instruction is captured exactly once, on the first edge with freeze_mem=0.
- Bubble input (valid_in=0): wb_en_out forced to 0 regardless of wb_en_in. Data fields are still captured, but they are don't-care for consumers.
- Retire event: an edge at which freeze_mem=0 and valid_in=1.
  - last_pc_out <= pc_in
  - retire_cnt increments by 1
  - load_cnt increments by 1 if mem_read_in=1
- stall_cnt increments by 1 on every edge at which freeze_mem=1, whether or not an instruction is present.
- Counters saturate at 2^CNT_W-1; they never wrap.
- clr_cnt=1 sets all three counters to 0 at the edge. Clear wins over a simultaneous increment. clr_cnt does not affect last_pc_out or the pipeline fields.
- Write-back to R15 is passed through unchanged; PC redirection is not handled here.
- Forwarding consumers use wb_en_out/wb_dest_out/wb_value_out directly. These outputs are registered, with no combinational path from any input.

Decomposition:
- Widths (ADDRESS_LEN, REGISTER_LEN, REG_ADDR_LEN) come from the shared defines file used by all stages. No new typedefs.
- One sub-module, sat_counter (parameter W; inputs inc, clr; output count). It is asynchronous active-low reset, clear-priority and saturating, and is instantiated three times.
- The pipeline capture register and the write-back mux stay in mem_wb_stage.

Test Plan:
- Reset: drive nonzero inputs, pull rst low between edges -> all outputs 0 immediately; after release, valid_in=1, wb_en_in=1, dest_in=3, alu_res_in=0x1234, mem_read_in=0 -> next edge wb_en_out=1, wb_dest_out=3, wb_value_out=0x1234, retire_cnt=1.
- Load select: mem_read_in=1, mem_data_in=0xDEADBEEF, alu_res_in=0x400, dest_in=5 -> wb_value_out=0xDEADBEEF, load_cnt=1.
- Freeze: hold a load in MEM with freeze_mem=1 for 4 cycles, then 0 -> wb_en_out=0 for 4 cycles, then exactly one cycle with wb_en_out=1; stall_cnt=4, retire_cnt=1.
- Bubble: valid_in=0, wb_en_in=1 -> wb_en_out=0, valid_out=0, retire_cnt unchanged.
- Saturation/clear: CNT_W=4, retire 17 instructions -> retire_cnt=15; then clr_cnt=1 together with a retire -> retire_cnt=0 the next cycle.
- Back-to-back: retire PCs 0x0, 0x4, 0x8 on consecutive edges -> pc_out and last_pc_out step 0x0→0x4→0x8; retire_cnt=3.
